// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command receiver: command word field layout,
// byte-FSM state encoding and a helper that derives bytes per command word.
package uart_cmd_pkg;

    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 16;
    localparam int DATA_LSB = 16;
    localparam int DATA_W   = 8;
    localparam int MODE_BIT = 24;

    function automatic int bytes_per_cmd(input int width);
        return width / 8;
    endfunction

    localparam int BYTES_PER_CMD = bytes_per_cmd(32);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer on rx, mid-bit sampling FSM,
// registered byte_valid / frame_err strobes.
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 5208
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       rx_active
);

    localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;

    // Synchronizer resets to the idle (high) line level so reset release cannot fake a start bit
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_sync)
                        state <= START;
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt       <= '0;
                        byte_data <= {rx_sync, byte_data[7:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt        <= '0;
                        byte_valid <= rx_sync;
                        frame_err  <= !rx_sync;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_active = (state != IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver top: packs CMD_WIDTH/8 received bytes (first byte in LSBs)
// into one command word. Define UART_CMD_TIMEOUT_EN to drop stale partial words.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 5208,
    parameter int CMD_WIDTH        = 32,
    parameter int TIMEOUT_BITS     = 20
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx,
    output logic                 cmd_valid,
    output logic [CMD_WIDTH-1:0] cmd_data,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int NUM_BYTES = bytes_per_cmd(CMD_WIDTH);
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int STG_W     = CMD_WIDTH - 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    if (CLOCKS_PER_PULSE < 4 || CMD_WIDTH < 16 || (CMD_WIDTH % 8) != 0 || TIMEOUT_BITS < 1) begin : g_bad_params
        $error("uart_cmd_rx: illegal parameter combination");
    end

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             rx_active;
    logic [IDX_W-1:0] byte_idx;
    logic [STG_W-1:0] staging;
    logic             expire;

    uart_rx_byte #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
    ) u_rx_byte (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err),
        .rx_active (rx_active)
    );

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLOCKS_PER_PULSE;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Counts idle line time only while a partial word is held; a byte arriving wins over expiry
    always_ff @(posedge clk) begin
        if (!rstn)
            tmo_cnt <= '0;
        else if (byte_valid || frame_err || byte_idx == '0)
            tmo_cnt <= '0;
        else if (!rx_active && !expire)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign expire = (tmo_cnt == TMO_W'(TMO_LIMIT));
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            byte_idx  <= '0;
            staging   <= '0;
        end else begin
            cmd_valid <= 1'b0;
            if (frame_err) begin
                byte_idx <= '0;
                staging  <= '0;
            end else if (byte_valid) begin
                if (byte_idx == LAST_IDX) begin
                    cmd_data  <= {byte_data, staging};
                    cmd_valid <= 1'b1;
                    byte_idx  <= '0;
                end else begin
                    staging[{byte_idx, 3'b000} +: 8] <= byte_data;
                    byte_idx                         <= byte_idx + 1'b1;
                end
            end else if (expire) begin
                byte_idx <= '0;
                staging  <= '0;
            end
        end
    end

    assign busy = rx_active || (byte_idx != '0);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at 8 clocks per bit; expected words are hand-built
// from the bytes sent. Honours UART_CMD_TIMEOUT_EN for the stale-partial-word case.
module tb_uart_cmd_rx;
    import uart_cmd_pkg::*;

    localparam int CPP = 8;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        rx   = 1'b1;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        frame_err;
    logic        busy;

    int          testsRun = 0;
    int          failCount = 0;
    int          frameErrCount = 0;
    int          doublePulseCount = 0;
    int          frameBase;
    logic        prevValid = 1'b0;
    logic [31:0] words[$];
    logic [31:0] w;

    always #5 clk = ~clk;

    uart_cmd_rx #(
        .CLOCKS_PER_PULSE(CPP),
        .CMD_WIDTH       (32),
        .TIMEOUT_BITS    (20)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (rx),
        .cmd_valid(cmd_valid),
        .cmd_data (cmd_data),
        .frame_err(frame_err),
        .busy     (busy)
    );

    // Strobe monitor: logs every completed word and framing error, flags adjacent cmd_valid
    always @(negedge clk) begin
        if (rstn && cmd_valid)
            words.push_back(cmd_data);
        if (rstn && frame_err)
            frameErrCount <= frameErrCount + 1;
        if (rstn && cmd_valid && prevValid)
            doublePulseCount <= doublePulseCount + 1;
        prevValid <= cmd_valid;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        rx = 1'b0;
        idle(CPP);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPP);
        end
        rx = stopBit;
        idle(CPP);
        rx = 1'b1;
    endtask

    task automatic sendWord(input logic [31:0] word);
        for (int i = 0; i < BYTES_PER_CMD; i++)
            applyStimulus(word[8*i +: 8], 1'b1);
    endtask

    task automatic applyReset;
        rstn = 1'b0;
        rx   = 1'b1;
        idle(3);
        rstn = 1'b1;
        idle(2);
    endtask

    initial begin
        @(negedge clk);
        rstn = 1'b0;
        idle(4);
        checkOutput("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        checkOutput("reset_cmd_data", cmd_data, 32'd0);
        checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        idle(4);

        // Basic word; strobe lands two clocks after the final stop sample
        words.delete();
        applyStimulus(8'h34, 1'b1);
        applyStimulus(8'h12, 1'b1);
        applyStimulus(8'hAB, 1'b1);
        applyStimulus(8'h01, 1'b1);
        checkOutput("basic_strobe", {31'd0, cmd_valid}, 32'd1);
        checkOutput("basic_data_at_strobe", cmd_data, 32'h01AB1234);
        idle(1);
        checkOutput("basic_strobe_one_cycle", {31'd0, cmd_valid}, 32'd0);
        idle(10);
        checkOutput("basic_word_count", words.size(), 32'd1);
        w = words[0];
        checkOutput("basic_addr", {16'd0, w[ADDR_LSB +: ADDR_W]}, 32'h1234);
        checkOutput("basic_wdata", {24'd0, w[DATA_LSB +: DATA_W]}, 32'hAB);
        checkOutput("basic_mode", {31'd0, w[MODE_BIT]}, 32'd1);
        checkOutput("basic_busy_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of the third byte
        applyStimulus(8'hEF, 1'b1);
        applyStimulus(8'hBE, 1'b1);
        rx = 1'b0;
        idle(CPP);
        rx = 1'b1;
        idle(3);
        rstn = 1'b0;
        idle(2);
        checkOutput("midreset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        checkOutput("midreset_cmd_data", cmd_data, 32'd0);
        checkOutput("midreset_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        idle(4);
        words.delete();
        sendWord(32'hDEADBEEF);
        idle(10);
        checkOutput("postreset_count", words.size(), 32'd1);
        checkOutput("postreset_word", words[0], 32'hDEADBEEF);

        // Short low glitch must be rejected silently
        applyReset;
        words.delete();
        frameBase = frameErrCount;
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(2);
        checkOutput("glitch_busy_start", {31'd0, busy}, 32'd1);
        idle(20);
        checkOutput("glitch_busy_end", {31'd0, busy}, 32'd0);
        checkOutput("glitch_frame_err", frameErrCount - frameBase, 32'd0);
        checkOutput("glitch_no_word", words.size(), 32'd0);

        // Bad stop bit on the second byte drops the partial word
        frameBase = frameErrCount;
        applyStimulus(8'h11, 1'b1);
        checkOutput("ferr_busy_partial", {31'd0, busy}, 32'd1);
        applyStimulus(8'h22, 1'b0);
        idle(16);
        checkOutput("ferr_pulse", frameErrCount - frameBase, 32'd1);
        checkOutput("ferr_busy_cleared", {31'd0, busy}, 32'd0);
        checkOutput("ferr_no_word", words.size(), 32'd0);
        applyStimulus(8'h78, 1'b1);
        applyStimulus(8'h56, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        idle(10);
        checkOutput("ferr_recover_count", words.size(), 32'd1);
        checkOutput("ferr_recover_word", words[0], 32'h00005678);

        // Long idle inside a partial word
        applyReset;
        words.delete();
        applyStimulus(8'hAA, 1'b1);
        applyStimulus(8'hBB, 1'b1);
        idle(200);
        sendWord(32'h44332211);
        idle(10);
        checkOutput("timeout_count", words.size(), 32'd1);
`ifdef UART_CMD_TIMEOUT_EN
        checkOutput("timeout_word", words[0], 32'h44332211);
        checkOutput("timeout_busy", {31'd0, busy}, 32'd0);
`else
        checkOutput("timeout_word", words[0], 32'h2211BBAA);
        checkOutput("timeout_busy", {31'd0, busy}, 32'd1);
`endif

        // Two words with no idle between frames
        applyReset;
        words.delete();
        sendWord(32'h01AB1234);
        sendWord(32'hCAFEF00D);
        idle(10);
        checkOutput("b2b_count", words.size(), 32'd2);
        checkOutput("b2b_word0", words[0], 32'h01AB1234);
        checkOutput("b2b_word1", words[1], 32'hCAFEF00D);
        checkOutput("b2b_no_double_strobe", doublePulseCount, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Serial receiver and command-word assembler for the bus bridge master's UART link. Samples the asynchronous `rx` line, recovers 8N1 bytes and packs every four consecutive bytes into one 32-bit `{mode, data, addr}` command word. Each completed word is presented with a one-cycle strobe to the bridge's command FIFO enqueue logic. Malformed or abandoned frames are discarded, so the FIFO only ever sees complete words.

## Interface
Parameters:
- `CLOCKS_PER_PULSE`, 5208, clk cycles per UART bit period; must be ≥ 4.
- `CMD_WIDTH`, 32, command word width; must be a multiple of 8.
- `TIMEOUT_BITS`, 20, idle bit periods after which a partial word is dropped.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `rx`  in  1  asynchronous serial input, idle high.
- `cmd_valid`  out  1  one-cycle strobe; `cmd_data` holds a new word.
- `cmd_data`  out  CMD_WIDTH  last completed word; held until the next word.
- `frame_err`  out  1  one-cycle strobe on a bad stop bit.
- `busy`  out  1  high while a byte is in flight or a partial word is held.

## Operation
- Word layout:
  - `[15:0]` addr.
  - `[23:16]` write data.
  - `[24]` mode (1 = write).
  - `[31:25]` reserved, passed through unchanged.
- Byte order: the first byte received is `cmd_data[7:0]`. Bits within a byte are LSB first.
- `rx` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on synchronized `rx`=0.
  - START: wait CLOCKS_PER_PULSE/2 clocks, then resample. If `rx`=1 it was a glitch: return to IDLE with no output. If `rx`=0, go to DATA.
  - DATA: sample every CLOCKS_PER_PULSE clocks, 8 samples, then go to STOP.
  - STOP: after CLOCKS_PER_PULSE clocks, sample.
    - 1: emit byte_valid.
    - 0: pulse `frame_err`, drop the byte, and clear the partial word (byte index ← 0).
    - In both cases return to IDLE immediately; a new start bit may then be detected on the next cycle.
- Assembler:
  - Byte index counts 0..CMD_WIDTH/8−1 and shifts each byte into a staging register.
  - On the last byte: `cmd_data` ← {byte, staging}, `cmd_valid` pulses, index ← 0.
- Bit counter width is $clog2(CLOCKS_PER_PULSE). There is no overrun case: the next byte cannot complete before the assembler has consumed the current one.

## Timing
- Reset values: `cmd_valid`=0, `cmd_data`=0, `frame_err`=0, `busy`=0. FSM goes to IDLE, byte index to 0, timeout counter to 0.
- Reset mid-byte or mid-word discards all partial state. The next falling edge after reset release starts a fresh frame.
- Latency:
  - byte_valid is registered 1 clk after the stop-bit sample.
  - `cmd_valid` follows 1 clk later, i.e. 2 clk after the last stop-bit sample.
  - `frame_err` is asserted 1 clk after the bad stop sample.
- Synchronizer adds 2 clk to the start-edge detection.
- `cmd_valid` is never high on two consecutive cycles. There is no backpressure; the consumer must accept on the strobe.
- Back-to-back frames with zero idle between the stop bit and the next start bit are received without loss.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_BITS*CLOCKS_PER_PULSE+1) runs only while byte index ≠ 0 and the FSM is in IDLE.
  - It clears on every byte_valid and pauses on a start bit.
  - On reaching TIMEOUT_BITS*CLOCKS_PER_PULSE: byte index ← 0 and the staging register is cleared. No strobe is issued.
  - If byte_valid and expiry coincide, byte_valid wins: the counter clears and the byte is kept.
- Undefined: no counter. A partial word is held indefinitely until completed, a framing error occurs, or reset.

## Structure
- Package `uart_cmd_pkg` holds:
  - `ADDR_LSB`=0, `ADDR_W`=16, `DATA_LSB`=16, `DATA_W`=8, `MODE_BIT`=24.
  - `BYTES_PER_CMD`.
  - The byte-FSM state enum.
- Sub-module `uart_rx_byte` contains the synchronizer, byte FSM and bit counter. Outputs: `byte_valid`, `byte_data[7:0]`, `frame_err`, `rx_active`.
- The top level holds the assembler and the timeout logic.

## Test plan
All scenarios use CLOCKS_PER_PULSE=8, TIMEOUT_BITS=20.
- Bytes 0x34,0x12,0xAB,0x01 → one `cmd_valid` pulse 2 clk after the last stop sample; `cmd_data`=0x01AB1234.
- `rx` low for 2 clk, then high → no byte, no `frame_err`, `busy` returns low.
- Second byte sent with stop bit 0 → `frame_err` pulse. Then 0x78,0x56,0x00,0x00 → `cmd_data`=0x00005678.
- Macro on: send 0xAA,0xBB, idle 200 clk, then 0x11,0x22,0x33,0x44 → `cmd_data`=0x44332211. Macro off: the same stimulus yields 0x2211BBAA.
- Assert `rstn`=0 mid-data-bit of byte 3 → all outputs 0. After release, a full word 0xDEADBEEF is received correctly.
- Two words sent with no idle gap → exactly two `cmd_valid` pulses, each with the correct value.
